xvga_timing_gen: RTL and testbench

Generates the 1024x768 @ 60 Hz (65 MHz pixel clock) raster timing that drives the graphics path: hcount, vcount, hsync, vsync and blank. It also produces a once-per-frame tick and a frame counter for the game-state update logic. A configurable delay line re-times hsync/vsync/blank so they stay aligned with the pixel pipeline latency of the renderer.

---
 rtl/xvga_timing_gen_pkg.sv | 41 ++++
 rtl/xvga_timing_gen_if.sv | 25 ++
 rtl/xvga_timing_gen_sync_delay_line.sv | 36 +++
 rtl/xvga_timing_gen.sv | 113 +++++++++++
 tb/tb_xvga_timing_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/xvga_timing_gen_pkg.sv
// Shared timing constants and types for the 1024x768 @ 60 Hz raster generator.
package xvga_pkg;

    // Default 1024x768 @ 60 Hz timing (65 MHz pixel clock)
    localparam int H_ACTIVE_DEF   = 1024;
    localparam int H_FP_DEF       = 24;
    localparam int H_SYNC_DEF     = 136;
    localparam int H_BP_DEF       = 160;
    localparam int V_ACTIVE_DEF   = 768;
    localparam int V_FP_DEF       = 3;
    localparam int V_SYNC_DEF     = 6;
    localparam int V_BP_DEF       = 29;
    localparam int PIPE_DELAY_DEF = 2;

    // Derived positions for the default timing
    localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END   = HS_START + H_SYNC_DEF;
    localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END   = VS_START + V_SYNC_DEF;

    // Counter widths are fixed by the port list
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // Idle value loaded into the retiming stages: both syncs inactive, blanked
    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

    // Half-open range test lo <= value < hi
    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/xvga_timing_gen_if.sv
// Raster timing bundle from the generator to the graphics path.
interface xvga_timing_gen_if;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        hsync_dly;
    logic        vsync_dly;
    logic        blank_dly;
    logic        frame_tick;
    logic [7:0]  frame_count;

    modport master (
        output hcount, vcount, hsync, vsync, blank,
        output hsync_dly, vsync_dly, blank_dly,
        output frame_tick, frame_count
    );

    modport slave (
        input hcount, vcount, hsync, vsync, blank,
        input hsync_dly, vsync_dly, blank_dly,
        input frame_tick, frame_count
    );
endinterface

// File: rtl/xvga_timing_gen_sync_delay_line.sv
// Shift register that re-times {hsync, vsync, blank} to the renderer latency.
// DEPTH = 0 is a pure wire; otherwise every stage resets to the idle value.
module sync_delay_line
    import xvga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clock,
    input  logic  reset,
    input  sync_t sync_i,
    output sync_t sync_o
);

    if (DEPTH == 0) begin : g_bypass
        assign sync_o = sync_i;
    end else begin : g_pipe
        sync_t stage_q [DEPTH];

        // Shift one stage per clock; reset fills every stage with the idle value
        always_ff @(posedge clock) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= SYNC_IDLE;
                end
            end else begin
                stage_q[0] <= sync_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign sync_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/xvga_timing_gen.sv
// Free-running raster timing generator with frame tick/counter and a
// retimed copy of the sync/blank signals.
module xvga_timing_gen
    import xvga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic               clock,
    input  logic               reset,
    xvga_timing_gen_if.master  timing_o
);

    localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO       = H_ACTIVE + H_FP;
    localparam int HS_HI       = HS_LO + H_SYNC;
    localparam int VS_LO       = V_ACTIVE + V_FP;
    localparam int VS_HI       = VS_LO + V_SYNC;

    // Reject timing sets the counters cannot represent
    if (LINE_TOTAL > (1 << HCOUNT_W) || LINE_TOTAL < 1) begin : g_bad_h_total
        $error("xvga_timing_gen: line total does not fit hcount width");
    end
    if (FRAME_TOTAL > (1 << VCOUNT_W) || FRAME_TOTAL < 1) begin : g_bad_v_total
        $error("xvga_timing_gen: frame total does not fit vcount width");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("xvga_timing_gen: PIPE_DELAY must be 0..7");
    end

    logic [HCOUNT_W-1:0] hcount_q, hcount_d;
    logic [VCOUNT_W-1:0] vcount_q, vcount_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                blank_q, blank_d;
    logic                frame_tick_q, frame_tick_d;
    logic [7:0]          frame_count_q, frame_count_d;
    sync_t               raw_sync;
    sync_t               dly_sync;

    // Next raster position, and the sync/blank decode of that position so the
    // registered flags line up with the registered counters
    always_comb begin
        hcount_d      = hcount_q + 1'b1;
        vcount_d      = vcount_q;
        if (int'(hcount_q) == LINE_TOTAL - 1) begin
            hcount_d = '0;
            if (int'(vcount_q) == FRAME_TOTAL - 1) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + 1'b1;
            end
        end
        hsync_d       = !in_range(int'(hcount_d), HS_LO, HS_HI);
        vsync_d       = !in_range(int'(vcount_d), VS_LO, VS_HI);
        blank_d       = (int'(hcount_d) >= H_ACTIVE) || (int'(vcount_d) >= V_ACTIVE);
        frame_tick_d  = (hcount_d == '0) && (int'(vcount_d) == V_ACTIVE);
        // The count advances on the tick cycle, so it is visible one cycle later
        frame_count_d = frame_count_q + {7'd0, frame_tick_q};
    end

    // Timing state register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b0;
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign raw_sync = '{hsync: hsync_q, vsync: vsync_q, blank: blank_q};

    sync_delay_line #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clock  (clock),
        .reset  (reset),
        .sync_i (raw_sync),
        .sync_o (dly_sync)
    );

    assign timing_o.hcount      = hcount_q;
    assign timing_o.vcount      = vcount_q;
    assign timing_o.hsync       = hsync_q;
    assign timing_o.vsync       = vsync_q;
    assign timing_o.blank       = blank_q;
    assign timing_o.hsync_dly   = dly_sync.hsync;
    assign timing_o.vsync_dly   = dly_sync.vsync;
    assign timing_o.blank_dly   = dly_sync.blank;
    assign timing_o.frame_tick  = frame_tick_q;
    assign timing_o.frame_count = frame_count_q;

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Directed bench: default 1024x768 timing instance (PIPE_DELAY=2) for line-level
// checks, plus a reduced 16x10 raster (PIPE_DELAY=0) for frame-level checks.
`timescale 1ns/1ps
module tb_xvga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_s_n;

    xvga_timing_gen_if vid ();
    xvga_timing_gen_if vid_s ();

    xvga_timing_gen #(.PIPE_DELAY(2)) dut (
        .clock    (clk),
        .reset    (rst_n),
        .timing_o (vid)
    );

    // Small raster: line = 8+2+3+3 = 16, frame = 6+1+2+1 = 10 lines
    xvga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(0)
    ) dut_s (
        .clock    (clk),
        .reset    (rst_s_n),
        .timing_o (vid_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {hsync, vsync, blank} of the default instance, c cycles after (0,0)
    function automatic logic [2:0] dflt_sync(input int c);
        int h = c % 1344;
        int v = c / 1344;
        logic hs = !((h >= 1048) && (h <= 1183));
        logic vs = !((v >= 771) && (v <= 776));
        logic bl = (h >= 1024) || (v >= 768);
        return {hs, vs, bl};
    endfunction

    int eh, ev, n;
    int h_mis, v_mis, s_mis, d_mis, tk_mis, fc_mis, vs_edge_bad;
    int hs_low, vs_low, ticks, fc_exp;
    logic [2:0] exp_s, exp_d, got_s;
    logic ets, prev_vs;

    initial begin
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        repeat (3) tick();

        // Reset state of the default instance
        check_eq("rst_hcount", int'(vid.hcount), 0);
        check_eq("rst_vcount", int'(vid.vcount), 0);
        check_eq("rst_sync_hvb", int'({vid.hsync, vid.vsync, vid.blank}), 3'b110);
        check_eq("rst_tick_fc", int'({vid.frame_tick, vid.frame_count}), 0);
        check_eq("rst_dly_hvb", int'({vid.hsync_dly, vid.vsync_dly, vid.blank_dly}), 3'b111);

        // Release: the current cycle is cycle 0 at (0,0)
        rst_n = 1'b1;
        h_mis = 0; v_mis = 0; s_mis = 0; d_mis = 0; hs_low = 0; ticks = 0;
        for (int c = 0; c < 3188; c++) begin
            eh = c % 1344;
            ev = c / 1344;
            exp_s = dflt_sync(c);
            exp_d = (c < 2) ? 3'b111 : dflt_sync(c - 2);
            got_s = {vid.hsync, vid.vsync, vid.blank};
            if (int'(vid.hcount) != eh) h_mis++;
            if (int'(vid.vcount) != ev) v_mis++;
            if (got_s !== exp_s) s_mis++;
            if ({vid.hsync_dly, vid.vsync_dly, vid.blank_dly} !== exp_d) d_mis++;
            if (vid.frame_tick) ticks++;
            if (ev == 0 && vid.hsync == 1'b0) hs_low++;
            if (c == 1)    check_eq("dly_hold_c1", int'({vid.hsync_dly, vid.vsync_dly, vid.blank_dly}), 3'b111);
            if (c == 2)    check_eq("dly_first_c2", int'({vid.hsync_dly, vid.vsync_dly, vid.blank_dly}), 3'b110);
            if (c == 1023) check_eq("blank_h1023", int'(vid.blank), 0);
            if (c == 1024) check_eq("blank_h1024", int'(vid.blank), 1);
            if (c == 1047) check_eq("hsync_h1047", int'(vid.hsync), 1);
            if (c == 1048) check_eq("hsync_h1048", int'(vid.hsync), 0);
            if (c == 1183) check_eq("hsync_h1183", int'(vid.hsync), 0);
            if (c == 1184) check_eq("hsync_h1184", int'(vid.hsync), 1);
            if (c == 1343) check_eq("hv_end_line0", int'({vid.vcount, vid.hcount}), 1343);
            if (c == 1344) check_eq("hv_start_line1", int'({vid.vcount, vid.hcount}), 1 << 11);
            if (c == 1344) check_eq("blank_line1_h0", int'(vid.blank), 0);
            tick();
        end
        check_eq("dflt_hcount_mismatches", h_mis, 0);
        check_eq("dflt_vcount_mismatches", v_mis, 0);
        check_eq("dflt_sync_mismatches", s_mis, 0);
        check_eq("dflt_dly_mismatches", d_mis, 0);
        check_eq("dflt_hsync_low_line0", hs_low, 136);
        check_eq("dflt_no_tick_early", ticks, 0);

        // Mid-line reset at (500,2)
        check_eq("pre_rst_pos", int'({vid.vcount, vid.hcount}), (2 << 11) | 500);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_pos", int'({vid.vcount, vid.hcount}), 0);
        check_eq("mid_rst_sync", int'({vid.hsync, vid.vsync, vid.blank}), 3'b110);
        check_eq("mid_rst_dly", int'({vid.hsync_dly, vid.vsync_dly, vid.blank_dly}), 3'b111);
        rst_n = 1'b1;
        tick();
        check_eq("after_rst_pos", int'({vid.vcount, vid.hcount}), 1);
        check_eq("after_rst_dly", int'({vid.hsync_dly, vid.vsync_dly, vid.blank_dly}), 3'b111);

        // Small raster: reset state, PIPE_DELAY=0 means dly tracks raw
        check_eq("s_rst_pos", int'({vid_s.vcount, vid_s.hcount}), 0);
        check_eq("s_rst_sync", int'({vid_s.hsync, vid_s.vsync, vid_s.blank}), 3'b110);
        check_eq("s_rst_dly", int'({vid_s.hsync_dly, vid_s.vsync_dly, vid_s.blank_dly}), 3'b110);
        rst_s_n = 1'b1;
        h_mis = 0; v_mis = 0; s_mis = 0; d_mis = 0; tk_mis = 0; fc_mis = 0;
        vs_low = 0; ticks = 0; fc_exp = 0; vs_edge_bad = 0; prev_vs = 1'b1;
        for (int c = 0; c < 41060; c++) begin
            eh = c % 16;
            ev = (c / 16) % 10;
            exp_s = {!((eh >= 10) && (eh <= 12)), !((ev >= 7) && (ev <= 8)), (eh >= 8) || (ev >= 6)};
            ets = (eh == 0) && (ev == 6);
            got_s = {vid_s.hsync, vid_s.vsync, vid_s.blank};
            if (int'(vid_s.hcount) != eh) h_mis++;
            if (int'(vid_s.vcount) != ev) v_mis++;
            if (got_s !== exp_s) s_mis++;
            if ({vid_s.hsync_dly, vid_s.vsync_dly, vid_s.blank_dly} !== exp_s) d_mis++;
            if (vid_s.frame_tick !== ets) tk_mis++;
            if (int'(vid_s.frame_count) != fc_exp) fc_mis++;
            if (vid_s.frame_tick) ticks++;
            if (c < 160 && vid_s.vsync == 1'b0) vs_low++;
            if (vid_s.vsync !== prev_vs && eh != 0) vs_edge_bad++;
            prev_vs = vid_s.vsync;
            if (c == 96)    check_eq("s_tick_at_0_6", int'({vid_s.frame_tick, vid_s.frame_count}), 9'h100);
            if (c == 97)    check_eq("s_fc_after_tick", int'({vid_s.frame_tick, vid_s.frame_count}), 1);
            if (c == 111)   check_eq("s_vsync_before", int'(vid_s.vsync), 1);
            if (c == 112)   check_eq("s_vsync_first_low", int'(vid_s.vsync), 0);
            if (c == 159)   check_eq("s_frame_end_pos", int'({vid_s.vcount, vid_s.hcount}), (9 << 11) | 15);
            if (c == 160)   check_eq("s_frame_wrap_pos", int'({vid_s.vcount, vid_s.hcount}), 0);
            if (c == 40896) check_eq("s_fc_255", int'({vid_s.frame_tick, vid_s.frame_count}), 9'h1FF);
            if (c == 40897) check_eq("s_fc_wrap", int'(vid_s.frame_count), 0);
            if (ets) fc_exp = (fc_exp + 1) % 256;
            tick();
        end
        check_eq("s_hcount_mismatches", h_mis, 0);
        check_eq("s_vcount_mismatches", v_mis, 0);
        check_eq("s_sync_mismatches", s_mis, 0);
        check_eq("s_dly_mismatches", d_mis, 0);
        check_eq("s_tick_mismatches", tk_mis, 0);
        check_eq("s_fc_mismatches", fc_mis, 0);
        check_eq("s_tick_total", ticks, 257);
        check_eq("s_vsync_low_frame0", vs_low, 32);
        check_eq("s_vsync_mid_line_edges", vs_edge_bad, 0);

        // Mid-frame reset at (4,6) with frame_count=1
        check_eq("s_pre_rst_fc", int'(vid_s.frame_count), 1);
        rst_s_n = 1'b0;
        tick();
        check_eq("s_mid_rst_pos", int'({vid_s.vcount, vid_s.hcount}), 0);
        check_eq("s_mid_rst_tick_fc", int'({vid_s.frame_tick, vid_s.frame_count}), 0);
        check_eq("s_mid_rst_sync", int'({vid_s.hsync, vid_s.vsync, vid_s.blank}), 3'b110);
        rst_s_n = 1'b1;
        n = 0;
        while (vid_s.frame_tick !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check_eq("s_tick_after_rst_cycles", n, 96);
        tick();
        check_eq("s_fc_after_rst_tick", int'(vid_s.frame_count), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
